lc3b_mem_access: RTL and testbench

- Load/store memory access unit for the LC-3b datapath. It sits on the other side of the address/operand path from the operand mux.
- Accepts one LDR/LDB/STR/STB request per handshake. It drives a word-addressed memory port with byte-lane enables and waits for the memory ready signal.
- Returns load data to the register file, sign-extended for byte loads. Unaligned word accesses and memory timeouts are reported as faults.

---
 rtl/lc3b_mem_access.sv | 150 +++++++++++++++
 tb/tb_lc3b_mem_access.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_access.sv
// LC-3b load/store memory access unit: one LDR/LDB/STR/STB per handshake,
// word-addressed memory port with byte lanes, sign-extended byte loads, fault on misalignment/timeout.
module lc3b_mem_access #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_lane,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter compares against MAX_WAIT-1 so the abort lands on the MAX_WAIT-th idle ACCESS cycle.
  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic        r_byte;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_fault;

  logic        w_accept;
  logic        w_unaligned;
  logic        w_rsp_load;
  logic        w_rsp_fault_nxt;
  logic [15:0] w_rsp_rdata_nxt;
  logic [15:0] w_load_data;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_unaligned = !req_byte && req_addr[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_byte  <= req_byte;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= '0;
      end else if (r_state == S_ACCESS && !mem_r) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_rsp_load) begin
        r_rsp_rdata <= w_rsp_rdata_nxt;
        r_rsp_fault <= w_rsp_fault_nxt;
      end
    end
  end

  always_comb begin
    w_load_data = '0;
    if (!r_we) begin
      if (r_byte) begin
        w_load_data = r_addr[0] ? {{8{mem_rdata[15]}}, mem_rdata[15:8]}
                                : {{8{mem_rdata[7]}},  mem_rdata[7:0]};
      end else begin
        w_load_data = mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_load      = 1'b0;
    w_rsp_fault_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_unaligned) begin
            w_state_nxt     = S_RESP;
            w_rsp_load      = 1'b1;
            w_rsp_fault_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // mem_r takes priority over the timeout in the same cycle.
        if (mem_r) begin
          w_state_nxt     = S_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_rdata_nxt = w_load_data;
        end else if (r_cnt == LIMIT) begin
          w_state_nxt     = S_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_fault_nxt = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = r_rsp_rdata;
    rsp_fault = r_rsp_fault;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_lane  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = r_we;
      mem_addr  = {r_addr[15:1], 1'b0};
      mem_wdata = r_byte ? {r_wdata[7:0], r_wdata[7:0]} : r_wdata;
      if (r_we) begin
        mem_lane = r_byte ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_lc3b_mem_access.sv
// Directed bench for lc3b_mem_access: hand-computed memory-port and response values per scenario.
module tb_lc3b_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_lane;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_r = 1'b0;

  int checks = 0;
  int errors = 0;

  lc3b_mem_access #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_lane(mem_lane), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_r(mem_r)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one aligned request; mem_r is raised on ACCESS cycle rdy_cyc (0 = never).
  task automatic run_access(input string nm, input logic we, input logic bt,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rdata, input int rdy_cyc,
                            input logic exp_we, input logic [1:0] exp_lane,
                            input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                            input logic [15:0] exp_rdata, input logic exp_fault);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_wdata = 16'h5A5A; req_addr = 16'hFFFF;
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if (mem_en !== 1'b1 || mem_we !== exp_we || mem_lane !== exp_lane ||
          mem_addr !== exp_addr || mem_wdata !== exp_wdata || req_ready !== 1'b0 ||
          rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s mem_cyc%0d: got en=%b we=%b lane=%b addr=%h wd=%h rdy=%b rv=%b want en=1 we=%b lane=%b addr=%h wd=%h rdy=0 rv=0",
                 nm, c, mem_en, mem_we, mem_lane, mem_addr, mem_wdata, req_ready, rsp_valid,
                 exp_we, exp_lane, exp_addr, exp_wdata);
      end
      mem_r     = (c == rdy_cyc);
      mem_rdata = (c == rdy_cyc) ? rdata : 16'hDEAD;
      step();
      mem_r = 1'b0; mem_rdata = 16'hBEEF;
      if (c == rdy_cyc) break;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_fault !== exp_fault || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp: got v=%b d=%h f=%b en=%b want v=1 d=%h f=%b en=0",
               nm, rsp_valid, rsp_rdata, rsp_fault, mem_en, exp_rdata, exp_fault);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== exp_rdata || rsp_fault !== exp_fault) begin
      errors++;
      $display("FAIL %s after_rsp: got v=%b rdy=%b d=%h f=%b want v=0 rdy=1 d=%h f=%b",
               nm, rsp_valid, req_ready, rsp_rdata, rsp_fault, exp_rdata, exp_fault);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_fault !== 1'b0 || mem_en !== 1'b0 ||
        mem_we !== 1'b0 || mem_lane !== 2'b00 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b d=%h f=%b en=%b we=%b lane=%b a=%h wd=%h want all 0",
               rsp_valid, rsp_rdata, rsp_fault, mem_en, mem_we, mem_lane, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_load();
    run_access("word_load", 1'b0, 1'b0, 16'h3002, 16'h0000, 16'h8001, 1,
               1'b0, 2'b00, 16'h3002, 16'h0000, 16'h8001, 1'b0);
  endtask

  task automatic test_byte_load();
    run_access("ldb_hi", 1'b0, 1'b1, 16'h3003, 16'h0000, 16'h80F7, 1,
               1'b0, 2'b00, 16'h3002, 16'h0000, 16'hFF80, 1'b0);
    run_access("ldb_lo", 1'b0, 1'b1, 16'h3002, 16'h0000, 16'h80F7, 1,
               1'b0, 2'b00, 16'h3002, 16'h0000, 16'hFFF7, 1'b0);
    run_access("ldb_pos", 1'b0, 1'b1, 16'h3003, 16'h0000, 16'h7F12, 1,
               1'b0, 2'b00, 16'h3002, 16'h0000, 16'h007F, 1'b0);
  endtask

  task automatic test_store();
    run_access("stb_hi", 1'b1, 1'b1, 16'h4001, 16'h12AB, 16'hFFFF, 1,
               1'b1, 2'b10, 16'h4000, 16'hABAB, 16'h0000, 1'b0);
    run_access("stb_lo", 1'b1, 1'b1, 16'h4000, 16'h3456, 16'hFFFF, 2,
               1'b1, 2'b01, 16'h4000, 16'h5656, 16'h0000, 1'b0);
    run_access("str", 1'b1, 1'b0, 16'h4000, 16'hC0DE, 16'hFFFF, 1,
               1'b1, 2'b11, 16'h4000, 16'hC0DE, 16'h0000, 1'b0);
  endtask

  task automatic test_unaligned();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL unaligned_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h4001; req_wdata = 16'h1111;
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 16'h0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_rsp: got v=%b f=%b d=%h en=%b want v=1 f=1 d=0000 en=0",
               rsp_valid, rsp_fault, rsp_rdata, mem_en);
    end
    step();
    checks++;
    if (mem_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL unaligned_after: got en=%b v=%b rdy=%b want en=0 v=0 rdy=1", mem_en, rsp_valid, req_ready);
    end
  endtask

  task automatic test_wait_timeout();
    run_access("timeout", 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h1234, 0,
               1'b0, 2'b00, 16'h2000, 16'h0000, 16'h0000, 1'b1);
    run_access("rdy_at_limit", 1'b0, 1'b0, 16'h2002, 16'h0000, 16'h4321, 15,
               1'b0, 2'b00, 16'h2002, 16'h0000, 16'h4321, 1'b0);
    run_access("wait3", 1'b1, 1'b0, 16'h2004, 16'h9876, 16'hFFFF, 3,
               1'b1, 2'b11, 16'h2004, 16'h9876, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h5000;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL midrst_access: got en=%b want 1", mem_en);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (mem_en !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_idle: got en=%b rdy=%b want en=0 rdy=1", mem_en, req_ready);
    end
    seen = 0;
    mem_r = 1'b1; mem_rdata = 16'hAAAA;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    mem_r = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_norsp: got %0d rsp_valid cycles want 0", seen);
    end
    run_access("after_rst", 1'b0, 1'b0, 16'h5002, 16'h0000, 16'h0F0F, 2,
               1'b0, 2'b00, 16'h5002, 16'h0000, 16'h0F0F, 1'b0);
  endtask

  task automatic test_back_to_back();
    mem_r = 1'b1; mem_rdata = 16'h1357;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h6000;
    step();
    req_addr = 16'h6010;
    checks++;
    if (req_ready !== 1'b0 || mem_addr !== 16'h6000) begin
      errors++; $display("FAIL b2b_first: got rdy=%b a=%h want rdy=0 a=6000", req_ready, mem_addr);
    end
    step();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h1357) begin
      errors++; $display("FAIL b2b_rsp1: got rdy=%b v=%b d=%h want rdy=0 v=1 d=1357", req_ready, rsp_valid, rsp_rdata);
    end
    mem_rdata = 16'h2468;
    step();
    checks++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got rdy=%b en=%b want rdy=1 en=0", req_ready, mem_en);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h6010) begin
      errors++; $display("FAIL b2b_second: got en=%b a=%h want en=1 a=6010", mem_en, mem_addr);
    end
    step();
    mem_r = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h2468 || rsp_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp2: got v=%b d=%h f=%b want v=1 d=2468 f=0", rsp_valid, rsp_rdata, rsp_fault);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_store();
    test_unaligned();
    test_wait_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
